ntt_radix_ct_twiddle_mult: RTL
==============================

# ntt_radix_ct_twiddle_mult

Pipelined twiddle-multiplication stage placed directly upstream of the radix-R Cooley-Tukey butterfly in the NTT datapath. Each of the R lanes is multiplied modulo MOD_M by its per-beat twiddle factor. Lane 0 always carries twiddle 1 and is a delay-matched bypass. The block also counts output beats and flags the last beat of each NTT block, so the downstream butterfly sees lane-aligned data at fixed latency.

## Interface
- R, 8: lane count, power of 2; elaboration fatal otherwise.
- OP_W, 32: operand width.
- MOD_M, 2**OP_W - 2**(OP_W/2) + 1: modulus, odd, < 2**OP_W.
- IN_PIPE, 1'b1: 1 adds an input register stage.
- SIDE_W, 0: side-data width, 0 = unused.
- RST_SIDE, 2'b00: [0]=1 resets side to all-0, [1]=1 resets side to all-1, 00 = no reset.
- BEAT_NB, 16: output beats per NTT block, >= 1.

Ports:
- clk  in  1  clock, rising edge.
- s_rst  in  1  reset, synchronous, active-high (one clock; polarity and synchronicity fixed).
- in_x  in  R*OP_W  operands, each < MOD_M.
- in_twd  in  R*OP_W  twiddles, each < MOD_M; lane 0 ignored.
- in_avail  in  R  per-lane valid.
- in_side  in  SIDE_W  side data, qualified by in_avail[0].
- out_x  out  R*OP_W  out_x[k] = in_x[k]*in_twd[k] mod MOD_M; out_x[0] = in_x[0].
- out_avail  out  R  per-lane valid.
- out_side  out  SIDE_W  side data aligned with lane 0.
- out_eob  out  1  pulses with out_avail[0] on the last beat of a block.

## Operation
- No backpressure. Every valid input produces exactly one valid output.
- Lanes are independent. Lane k output valid tracks in_avail[k] only.
- Per-lane pipeline for k >= 1:
  - optional input register (IN_PIPE);
  - s1: full 2*OP_W-bit product register;
  - s2: reduced result register, (product mod MOD_M) in [0, MOD_M-1].
- Lane 0: data passes through the same number of register stages with no arithmetic.
- Data registers load only when the matching avail is 1. While avail is 0 they hold their value; contents are don't-care.
- Side data travels with lane 0 and loads when avail[0] is 1. It uses RST_SIDE reset values, or is unreset when RST_SIDE = 00.
- Beat counter, range 0..BEAT_NB-1:
  - increments on each cycle with out_avail[0] = 1;
  - wraps to 0 after BEAT_NB-1;
  - out_eob = out_avail[0] AND (counter == BEAT_NB-1), combinational from counter and registered avail.
  - With BEAT_NB = 1, out_eob = out_avail[0].
- Reset:
  - out_avail = 0, counter = 0, out_eob = 0;
  - out_x is don't-care;
  - out_side is set by RST_SIDE.
- Reset mid-operation: all in-flight avail bits are cleared, in-flight beats are dropped, and the counter restarts at 0.
- Reset has priority over any simultaneous in_avail.

## Timing
- Latency = 2 + IN_PIPE cycles, identical for all lanes, side data and out_eob.
- Throughput: one beat per cycle per lane, unlimited back-to-back.
- First valid output after reset deassert is possible at cycle 2 + IN_PIPE after the first in_avail.
- Partial-lane beats (some in_avail bits 0) are legal. Only lane 0 beats advance the counter.

## Test plan
- Defaults, IN_PIPE=1. Lane 1: x=2, twd=3 -> out_x[1]=6, exactly 3 cycles later, out_avail[1]=1 for one cycle.
- Lane 3: x=4294901760, twd=4294901760 -> out_x[3]=1. Lane 2: x=2147483648, twd=2 -> out_x[2]=65535.
- Lane 0: x=12345, in_twd[0]=999 -> out_x[0]=12345. SIDE_W=4, in_side=4'hA -> out_side=4'hA on the same cycle.
- 40 back-to-back full beats with random operands against a reference model. out_eob is high on output beats 16 and 32 (1-based) and nowhere else; the counter is 8 at the end.
- Assert s_rst for 1 cycle while 2 beats are in flight. Neither emerges, out_avail stays 0, and the next block's out_eob falls on its 16th beat.
- IN_PIPE=0, in_avail=8'b1000_0001 -> out_avail=8'b1000_0001 after 2 cycles, and lanes 1-6 stay 0.

Source files
------------

// File: rtl/ntt_radix_ct_twiddle_mult.sv
// ---------------------------------------------------------------------------
// ntt_radix_ct_twiddle_mult
//
// Twiddle-multiplication stage that sits in front of a radix-R Cooley-Tukey
// butterfly. Lane k (k >= 1) computes in_x[k] * in_twd[k] mod MOD_M; lane 0
// always carries twiddle 1 and is a delay-matched bypass. Side data travels
// with lane 0. A beat counter flags the last output beat of each NTT block.
// Latency is 2 + IN_PIPE cycles for every lane, the side data and out_eob.
//
// Ports
//   clk        rising-edge clock
//   s_rst      synchronous active-high reset
//   in_x       R packed operands, lane k at [k*OP_W +: OP_W], each < MOD_M
//   in_twd     R packed twiddles, lane 0 ignored, each < MOD_M
//   in_avail   per-lane input valid
//   in_side    side data, qualified by in_avail[0]
//   out_x      R packed results, out_x[0] = in_x[0]
//   out_avail  per-lane output valid
//   out_side   side data aligned with lane 0
//   out_eob    high with out_avail[0] on the last beat of a block
// ---------------------------------------------------------------------------
module ntt_radix_ct_twiddle_mult #(
  parameter int          R        = 8,
  parameter int          OP_W     = 32,
  parameter logic [63:0] MOD_M    = (64'd1 << OP_W) - (64'd1 << (OP_W / 2)) + 64'd1,
  parameter bit          IN_PIPE  = 1'b1,
  parameter int          SIDE_W   = 0,
  parameter logic [1:0]  RST_SIDE = 2'b00,
  parameter int          BEAT_NB  = 16
) (
  input  logic                                   clk,
  input  logic                                   s_rst,
  input  logic [R*OP_W-1:0]                      in_x,
  input  logic [R*OP_W-1:0]                      in_twd,
  input  logic [R-1:0]                           in_avail,
  input  logic [((SIDE_W > 0) ? SIDE_W : 1)-1:0] in_side,
  output logic [R*OP_W-1:0]                      out_x,
  output logic [R-1:0]                           out_avail,
  output logic [((SIDE_W > 0) ? SIDE_W : 1)-1:0] out_side,
  output logic                                   out_eob
);

  // A zero-width side bus is carried as one unused bit.
  localparam int              SW        = (SIDE_W > 0) ? SIDE_W : 1;
  localparam bit              SIDE_RST  = (RST_SIDE != 2'b00);
  localparam logic [SW-1:0]   SIDE_INIT = RST_SIDE[1] ? {SW{1'b1}} : {SW{1'b0}};
  localparam int              CNT_W     = (BEAT_NB > 1) ? $clog2(BEAT_NB) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEAT_NB - 1);
  localparam logic [2*OP_W-1:0] MOD_W   = (2*OP_W)'(MOD_M);

  // -------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // -------------------------------------------------------------------------
  if ((R < 1) || ((R & (R - 1)) != 0)) begin : g_chk_r
    $fatal(1, "ntt_radix_ct_twiddle_mult: R must be a power of 2");
  end
  if ((OP_W < 2) || (OP_W > 64)) begin : g_chk_op_w
    $fatal(1, "ntt_radix_ct_twiddle_mult: OP_W must be in 2..64");
  end
  if (BEAT_NB < 1) begin : g_chk_beat_nb
    $fatal(1, "ntt_radix_ct_twiddle_mult: BEAT_NB must be >= 1");
  end
  if ((MOD_M[0] == 1'b0) || ((MOD_M >> OP_W) != 64'd0)) begin : g_chk_mod
    $fatal(1, "ntt_radix_ct_twiddle_mult: MOD_M must be odd and < 2**OP_W");
  end

  // -------------------------------------------------------------------------
  // Valid pipeline: av0 feeds s1, av1 feeds s2, av2 is the output valid.
  // Reset clears every stage, dropping in-flight beats, and wins over a
  // simultaneous in_avail.
  // -------------------------------------------------------------------------
  logic [R-1:0] av0;
  logic [R-1:0] av1;
  logic [R-1:0] av2;

  if (IN_PIPE) begin : g_av_in
    logic [R-1:0] av_q;
    always_ff @(posedge clk) begin
      if (s_rst) av_q <= '0;
      else       av_q <= in_avail;
    end
    assign av0 = av_q;
  end else begin : g_av_thru
    assign av0 = in_avail;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments, so each stage samples the pre-edge value of the stage before it.
    if (s_rst) begin
      av1 <= '0;
      av2 <= '0;
    end else begin
      av1 <= av0;
      av2 <= av1;
    end
  end

  assign out_avail = av2;

  // -------------------------------------------------------------------------
  // Per-lane datapath
  // -------------------------------------------------------------------------
  for (genvar k = 0; k < R; k++) begin : g_lane
    logic [OP_W-1:0] x_s;
    logic [OP_W-1:0] r2_q;

    if (IN_PIPE) begin : g_x_in
      logic [OP_W-1:0] x_q;
      // NOTE: datapath registers have no reset; only the valid bits need a defined state.
      always_ff @(posedge clk) begin
        if (in_avail[k]) x_q <= in_x[k*OP_W +: OP_W];
      end
      assign x_s = x_q;
    end else begin : g_x_thru
      assign x_s = in_x[k*OP_W +: OP_W];
    end

    if (k == 0) begin : g_bypass
      // Twiddle is 1 by construction: two plain delay registers.
      logic [OP_W-1:0] d1_q;
      always_ff @(posedge clk) begin
        if (av0[0]) d1_q <= x_s;
        if (av1[0]) r2_q <= d1_q;
      end
    end else begin : g_mult
      logic [OP_W-1:0]   t_s;
      logic [2*OP_W-1:0] p1_q;
      logic [OP_W-1:0]   rem_lo;
      logic [OP_W-1:0]   unused_rem_hi;

      if (IN_PIPE) begin : g_t_in
        logic [OP_W-1:0] t_q;
        always_ff @(posedge clk) begin
          if (in_avail[k]) t_q <= in_twd[k*OP_W +: OP_W];
        end
        assign t_s = t_q;
      end else begin : g_t_thru
        assign t_s = in_twd[k*OP_W +: OP_W];
      end

      // Both operands are < MOD_M, so the product is < MOD_M**2 and one
      // constant-modulus remainder lands in [0, MOD_M-1]; the upper half of
      // the remainder is always zero.
      assign {unused_rem_hi, rem_lo} = p1_q % MOD_W;

      always_ff @(posedge clk) begin
        if (av0[k]) p1_q <= (2*OP_W)'(x_s) * (2*OP_W)'(t_s);
        if (av1[k]) r2_q <= rem_lo;
      end
    end

    assign out_x[k*OP_W +: OP_W] = r2_q;
  end

  // Lane 0 twiddle is architecturally ignored.
  logic unused_twd0;
  assign unused_twd0 = ^in_twd[OP_W-1:0];

  // -------------------------------------------------------------------------
  // Side data, following lane 0's valid through the same stages
  // -------------------------------------------------------------------------
  logic [SW-1:0] side0;
  logic [SW-1:0] side1_q;
  logic [SW-1:0] side2_q;

  if (IN_PIPE) begin : g_side_in
    logic [SW-1:0] side_q;
    always_ff @(posedge clk) begin
      if (SIDE_RST && s_rst) side_q <= SIDE_INIT;
      else if (in_avail[0])  side_q <= in_side;
    end
    assign side0 = side_q;
  end else begin : g_side_thru
    assign side0 = in_side;
  end

  always_ff @(posedge clk) begin
    if (SIDE_RST && s_rst) begin
      side1_q <= SIDE_INIT;
      side2_q <= SIDE_INIT;
    end else begin
      if (av0[0]) side1_q <= side0;
      if (av1[0]) side2_q <= side1_q;
    end
  end

  assign out_side = side2_q;

  // -------------------------------------------------------------------------
  // Output beat counter; only lane 0 beats advance it.
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (s_rst) begin
      cnt_q <= '0;
    end else if (av2[0]) begin
      cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // With BEAT_NB = 1 the counter is pinned at 0 == CNT_LAST, so every lane 0 beat is a last beat.
  assign out_eob = av2[0] && (cnt_q == CNT_LAST);

endmodule
